// File: rtl/rf_wb_arbiter_pkg.sv
// ============================================================================
// rf_wb_arbiter_pkg : register-file addressing types shared by the core.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_e;

endpackage

`default_nettype wire

// File: rtl/rf_pend_counter.sv
// ============================================================================
// rf_pend_counter : saturating outstanding-write counter for one register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_pend_counter #(
  parameter int NUM_PEND = 3,
  parameter int CNT_W    = $clog2(NUM_PEND + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic             unf_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A simultaneous inc and dec cancel, so neither can overflow nor underflow.
  assign ovf_o = inc_i && !dec_i && (count_q == CNT_W'(NUM_PEND));
  assign unf_o = dec_i && !inc_i && (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !ovf_o) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec_i && !inc_i && !unf_o) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign busy_o  = (count_q != '0);

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// rf_wb_arbiter : round-robin arbiter of two writeback channels onto the
//                 register file write port, with per-register pending tracking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PEND   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  reg_addr_t             a_rd,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  reg_addr_t             b_rd,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  wr_en,
  output reg_addr_t             wr_rd,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  issue_valid,
  input  reg_addr_t             issue_rd,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  err
);

  localparam int CNT_W = $clog2(NUM_PEND + 1);

  chan_e                 prio_q, prio_d;
  logic                  wr_en_q, wr_en_d;
  reg_addr_t             wr_rd_q, wr_rd_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  err_q, err_d;

  logic                  xfer;
  reg_addr_t             sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [NUM_REGS-1:1]            cnt_busy;
  logic [NUM_REGS-1:1]            cnt_ovf;
  logic [NUM_REGS-1:1]            cnt_unf;
  logic [NUM_REGS-1:1][CNT_W-1:0] cnt_val;
  logic                           unused_cnt_val;

  // prio_q names the channel that wins when both request.
  assign a_ready  = rst_n && a_valid && (!b_valid || (prio_q == CH_A));
  assign b_ready  = rst_n && b_valid && (!a_valid || (prio_q == CH_B));
  assign xfer     = a_ready || b_ready;
  assign sel_rd   = a_ready ? a_rd   : b_rd;
  assign sel_data = a_ready ? a_data : b_data;

  always_comb begin
    prio_d    = prio_q;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    wr_en_d   = xfer && (sel_rd != '0);
    if (xfer) begin
      prio_d    = a_ready ? CH_B : CH_A;
      wr_rd_d   = sel_rd;
      wr_data_d = sel_data;
    end
    err_d = err_q || (|cnt_ovf) || (|cnt_unf);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q    <= CH_A;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  // x0 is hardwired, so it gets no counter.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    rf_pend_counter #(
      .NUM_PEND (NUM_PEND),
      .CNT_W    (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (issue_valid && (issue_rd == reg_addr_t'(r))),
      .dec_i   (wr_en_q && (wr_rd_q == reg_addr_t'(r))),
      .count_o (cnt_val[r]),
      .busy_o  (cnt_busy[r]),
      .ovf_o   (cnt_ovf[r]),
      .unf_o   (cnt_unf[r])
    );
  end

  assign unused_cnt_val = ^cnt_val;

  assign busy    = {cnt_busy, 1'b0};
  assign wr_en   = wr_en_q;
  assign wr_rd   = wr_rd_q;
  assign wr_data = wr_data_q;
  assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// tb_rf_wb_arbiter : directed and random stimulus against a reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int NP = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid, issue_valid;
  logic [4:0]    a_rd, b_rd, issue_rd;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, wr_en, err;
  logic [4:0]    wr_rd;
  logic [DW-1:0] wr_data;
  logic [31:0]   busy;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: pending counts, sticky error, expected write port, tie winner.
  int          m_cnt [32];
  bit          m_err;
  bit          m_wen;
  logic [4:0]  m_wrd;
  logic [31:0] m_wdat;
  bit          m_prio_b;
  bit          g_a, g_b;

  bit          ha_v, hb_v;
  logic [4:0]  ha_rd, hb_rd;
  logic [31:0] ha_d, hb_d;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_WIDTH(DW), .NUM_PEND(NP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_valid     (a_valid),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .wr_en       (wr_en),
    .wr_rd       (wr_rd),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] v = '0;
    for (int r = 1; r < 32; r++) v[r] = (m_cnt[r] != 0);
    return v;
  endfunction

  task automatic step(input bit rst, input bit av, input logic [4:0] ard, input logic [31:0] adat,
                      input bit bv, input logic [4:0] brd, input logic [31:0] bdat,
                      input bit iv, input logic [4:0] ird);
    int delta;
    @(negedge clk);
    rst_n = rst; a_valid = av; a_rd = ard; a_data = adat;
    b_valid = bv; b_rd = brd; b_data = bdat;
    issue_valid = iv; issue_rd = ird;
    #1;
    g_a = rst && av && (!bv || !m_prio_b);
    g_b = rst && bv && (!av || m_prio_b);
    chk("a_ready", {31'b0, a_ready}, {31'b0, g_a});
    chk("b_ready", {31'b0, b_ready}, {31'b0, g_b});
    chk("wr_en",   {31'b0, wr_en},   {31'b0, m_wen});
    if (m_wen) begin
      chk("wr_rd",   {27'b0, wr_rd}, {27'b0, m_wrd});
      chk("wr_data", wr_data,        m_wdat);
    end
    chk("busy", busy, m_busy());
    chk("err",  {31'b0, err}, {31'b0, m_err});
    @(posedge clk);
    if (!rst) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_err = 0; m_wen = 0; m_wrd = '0; m_wdat = '0; m_prio_b = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        delta = ((iv && ird == r) ? 1 : 0) - ((m_wen && m_wrd == r) ? 1 : 0);
        if (delta > 0) begin
          if (m_cnt[r] == NP) m_err = 1; else m_cnt[r]++;
        end else if (delta < 0) begin
          if (m_cnt[r] == 0) m_err = 1; else m_cnt[r]--;
        end
      end
      if (g_a) begin
        m_wen = (ard != 0); m_wrd = ard; m_wdat = adat; m_prio_b = 1;
      end else if (g_b) begin
        m_wen = (brd != 0); m_wrd = brd; m_wdat = bdat; m_prio_b = 0;
      end else begin
        m_wen = 0;
      end
    end
  endtask

  task automatic idle(input bit iv, input logic [4:0] ird);
    step(1, 0, 0, 0, 0, 0, 0, iv, ird);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; a_valid = 0; b_valid = 0; issue_valid = 0;
    a_rd = 0; b_rd = 0; issue_rd = 0; a_data = 0; b_data = 0;
    do_reset();
    #1;
    chk("rst_wr_rd",   {27'b0, wr_rd}, 32'd0);
    chk("rst_wr_data", wr_data,        32'd0);

    // Single A request: written one cycle later.
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    #1;
    chk("a_only_wr_en",   {31'b0, wr_en}, 32'd1);
    chk("a_only_wr_rd",   {27'b0, wr_rd}, 32'd5);
    chk("a_only_wr_data", wr_data,        32'hDEADBEEF);
    idle(0, 0);

    // Both valid after reset alternate starting with A.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 32'h1000 + i, 1, 2, 32'h2000, 0, 0);
      #1;
      chk("rr_wr_rd", {27'b0, wr_rd}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    idle(0, 0);

    // rd=0 from B is consumed silently; next tie goes to A.
    step(1, 0, 0, 0, 1, 0, 32'h1234, 0, 0);
    #1;
    chk("x0_no_write", {31'b0, wr_en}, 32'd0);
    step(1, 1, 3, 32'hA, 1, 4, 32'hB, 0, 0);
    idle(0, 0);
    idle(0, 0);

    // Saturation at NUM_PEND and drain to idle.
    do_reset();
    for (int i = 0; i < 4; i++) idle(1, 7);
    #1;
    chk("sat_busy7", {31'b0, busy[7]}, 32'd1);
    chk("sat_err",   {31'b0, err},     32'd1);
    for (int i = 0; i < 3; i++) step(1, 1, 7, 32'h70 + i, 0, 0, 0, 0, 0);
    idle(0, 0);
    #1;
    chk("drain_busy7", {31'b0, busy[7]}, 32'd0);

    // Simultaneous increment and decrement of register 9.
    do_reset();
    idle(1, 9);
    step(1, 1, 9, 32'h99, 0, 0, 0, 0, 0);
    idle(1, 9);
    #1;
    chk("incdec_busy9", {31'b0, busy[9]}, 32'd1);
    chk("incdec_err",   {31'b0, err},     32'd0);

    // Reset while requests and pending state are present.
    idle(1, 3);
    step(0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0);
    step(1, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0);
    idle(0, 0);

    // Random traffic honouring the hold-until-granted rule.
    ha_v = 0; hb_v = 0; ha_rd = 0; hb_rd = 0; ha_d = 0; hb_d = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ha_v) begin
        ha_v = ($urandom_range(0, 2) != 0); ha_rd = 5'($urandom_range(0, 7)); ha_d = $urandom;
      end
      if (!hb_v) begin
        hb_v = ($urandom_range(0, 2) != 0); hb_rd = 5'($urandom_range(0, 7)); hb_d = $urandom;
      end
      step(($urandom_range(0, 59) != 0), ha_v, ha_rd, ha_d, hb_v, hb_rd, hb_d,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)));
      if (g_a) ha_v = 0;
      if (g_b) hb_v = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
